// File: rtl/sfq_mp_stimulus_tx.sv
// sfq_mp_stimulus_tx: buffers stimulus words and replays them as
// one-cycle SFQ pulse vectors, one word per NPHASES-phase epoch.
module sfq_mp_stimulus_tx #(
  parameter int WIDTH   = 8,
  parameter int NPHASES = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic [NPHASES-1:0]       phase_oh,
  output logic [WIDTH-1:0]         pulse_out,
  output logic                     pulse_valid,
  output logic [7:0]               underrun_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(NPHASES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } st_t;

  st_t state;
  st_t state_nx;

  logic [PW-1:0]      phase_cnt;
  logic [PW-1:0]      phase_nx;
  logic [NPHASES-1:0] phase_oh_nx;
  logic [WIDTH-1:0]   pulse_nx;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [LW-1:0]      level_nx;
  logic               empty;
  logic               last;
  logic               ese;
  logic               push;
  logic               pop;
  logic               und;

  assign empty = (level == '0);
  assign last  = (phase_cnt == PW'(NPHASES - 1));
  assign ese   = (state == IDLE) ? en : last;
  assign push  = in_valid & in_ready;
  assign pop   = ese & ~empty;
  // An empty epoch counts unless we are only draining out
  assign und   = ese & empty & (state != DRAIN);

  assign level_nx = level + LW'(push) - LW'(pop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (en) state_nx = RUN;
      RUN:   if (!en) state_nx = DRAIN;
      DRAIN: begin
        if (en)               state_nx = RUN;
        else if (ese && empty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    phase_nx    = '0;
    phase_oh_nx = '0;
    pulse_nx    = '0;
    if (state_nx != IDLE && !ese)
      phase_nx = phase_cnt + PW'(1);
    if (state_nx != IDLE)
      phase_oh_nx = NPHASES'(1) << phase_nx;
    if (pop)
      pulse_nx = mem[rptr];
  end

  // Phase counter, pulse outputs, FIFO bookkeeping and underrun count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt    <= '0;
      phase_oh     <= '0;
      pulse_out    <= '0;
      pulse_valid  <= 1'b0;
      underrun_cnt <= '0;
      level        <= '0;
      in_ready     <= 1'b1;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      phase_cnt   <= phase_nx;
      phase_oh    <= phase_oh_nx;
      pulse_out   <= pulse_nx;
      pulse_valid <= pop;
      level       <= level_nx;
      in_ready    <= (level_nx != LW'(DEPTH));
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (und && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: tb/tb_sfq_mp_stimulus_tx.sv
// tb_sfq_mp_stimulus_tx: directed stimulus with a pulse scoreboard
// and directed checks on phase, level and underrun outputs.
module tb_sfq_mp_stimulus_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [3:0] phase_oh;
  logic [7:0] pulse_out;
  logic       pulse_valid;
  logic [7:0] underrun_cnt;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int pulse_cyc[$];

  sfq_mp_stimulus_tx #(.WIDTH(8), .NPHASES(4), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .phase_oh(phase_oh),
    .pulse_out(pulse_out),
    .pulse_valid(pulse_valid),
    .underrun_cnt(underrun_cnt),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (pulse_valid) begin
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected act=%h req=none", pulse_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (pulse_out !== e) begin
            failures++;
            $display("FAIL pulse_data act=%h req=%h", pulse_out, e);
          end
        end
      end else if (pulse_out !== 8'h00) begin
        failures++;
        $display("FAIL pulse_idle act=%h req=00", pulse_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    exp_q.delete();
    pulse_cyc.delete();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input bit track);
    in_valid = 1'b1;
    in_data = d;
    if (track) exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_times(input string name, input int c0,
                           input int n);
    chk({name, "_count"}, pulse_cyc.size(), n);
    for (int i = 0; i < n; i++)
      if (i < pulse_cyc.size())
        chk({name, "_cycle"}, pulse_cyc[i] - c0, 1 + 4 * i);
  endtask

  initial begin
    int c0;
    bit acc;
    logic [7:0] w [5];
    w[0] = 8'h01; w[1] = 8'h82; w[2] = 8'h43;
    w[3] = 8'hC4; w[4] = 8'h25;

    // 1: reset mid-run, with a pulse in flight
    do_reset();
    mon_en = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_underrun", underrun_cnt, 2);
    push(8'h11, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      tick();
      acc = pulse_valid;
    end
    chk("pre_rst_pulse", {pulse_valid, pulse_out}, {1'b1, 8'h11});
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_pulse_valid", pulse_valid, 0);
    chk("rst_phase_oh", phase_oh, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underrun", underrun_cnt, 0);

    // 2: two words, phase sequence and pulse timing
    do_reset();
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_phase_oh", phase_oh, 32'd1 << (i % 4));
    end
    chk_times("t2_pulse", c0, 2);
    chk("t2_drained", exp_q.size(), 0);

    // 3: three empty epochs
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t3_underrun", underrun_cnt, 3);
    chk("t3_pulses", pulse_cyc.size(), 0);

    // 4: five words back-to-back, fifth held off
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = w[i];
      chk("t4_ready_pre", in_ready, 1);
      exp_q.push_back(w[i]);
      tick();
    end
    in_data = w[4];
    chk("t4_ready_full", in_ready, 0);
    chk("t4_level_full", level, 4);
    tick();
    chk("t4_hold_level", level, 4);
    en = 1'b1;
    c0 = cyc;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      if (in_ready) begin
        exp_q.push_back(w[4]);
        acc = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t4_fifth_accepted", acc, 1);
    for (int i = 0; i < 18; i++) tick();
    chk_times("t4_pulse", c0, 5);
    chk("t4_drained", exp_q.size(), 0);

    // 5: short en pulse then DRAIN to IDLE
    do_reset();
    push(8'h5A, 1'b1);
    push(8'hF0, 1'b1);
    en = 1'b1;
    c0 = cyc;
    tick();
    en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_drain_phase", phase_oh, 4'b1000);
    tick();
    chk("t5_idle_phase", phase_oh, 0);
    chk("t5_underrun", underrun_cnt, 0);
    chk_times("t5_pulse", c0, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_stays_idle", phase_oh, 0);

    // 6a: underrun saturation
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 1204; i++) tick();
    chk("t6_underrun_sat", underrun_cnt, 255);

    // 6b: push during a pop edge at level 2
    do_reset();
    push(8'h10, 1'b1);
    push(8'h20, 1'b1);
    push(8'h30, 1'b1);
    chk("t6_level3", level, 3);
    en = 1'b1;
    tick();
    chk("t6_level_after_pop", level, 2);
    for (int i = 0; i < 3; i++) tick();
    push(8'h40, 1'b1);
    chk("t6_level_pushpop", level, 2);
    for (int i = 0; i < 12; i++) tick();
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_level_empty", level, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
